// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-requester SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF      = 24;
  localparam int DATA_W_DEF      = 16;
  localparam int MAX_PENDING_DEF = 4;

  typedef logic req_id_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester ids for reads that are still awaiting data.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_PENDING_DEF
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  req_id_t push_id_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output req_id_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_id_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == CNT_W'(0));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      cnt_q    <= CNT_W'(0);
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller Avalon-MM port between two requesters.
// Define SDRAM_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_be,
  output logic                s_read,
  output logic                s_write,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rvalid,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;

  state_t            state_q, state_d;
  req_id_t           grant_q, grant_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [BE_W-1:0]   s_be_q, s_be_d;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              err_q, err_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  req_id_t           last_grant_q, last_grant_d;
`endif

  logic    elig0, elig1, win_valid;
  req_id_t win_id;
  logic    accept;
  logic    push, pop;
  logic    fifo_full, fifo_empty;
  req_id_t fifo_head;

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clk_i     (CLOCK_50),
    .rst_i     (RESET),
    .push_i    (push),
    .push_id_i (grant_q),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (fifo_head)
  );

  assign accept = (state_q == ISSUE) && !s_waitrequest;

  // Eligibility and winner selection for the next IDLE evaluation.
  always_comb begin
    elig0     = m0_write || (m0_read && !fifo_full);
    elig1     = m1_write || (m1_read && !fifo_full);
    win_valid = elig0 || elig1;
    if (elig0 && elig1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      win_id = 1'b0;
`else
      win_id = ~last_grant_q;
`endif
    end else if (elig1) begin
      win_id = 1'b1;
    end else begin
      win_id = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = ISSUE;
          grant_d = win_id;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          last_grant_d = win_id;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (accept) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    s_read_d  = s_read_q;
    s_write_d = s_write_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!win_valid) begin
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
        end else if (win_id == 1'b1) begin
          s_addr_d  = m1_addr;
          s_wdata_d = m1_wdata;
          s_be_d    = m1_be;
          s_read_d  = m1_read;
          s_write_d = m1_write;
        end else begin
          s_addr_d  = m0_addr;
          s_wdata_d = m0_wdata;
          s_be_d    = m0_be;
          s_read_d  = m0_read;
          s_write_d = m0_write;
        end
      end
      ISSUE: begin
        if (accept) begin
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          push      = s_read_q;
        end else begin
          push      = 1'b0;
        end
      end
      default: begin
        s_read_d  = 1'b0;
        s_write_d = 1'b0;
      end
    endcase
    m0_waitrequest = !(accept && (grant_q == 1'b0));
    m1_waitrequest = !(accept && (grant_q == 1'b1));
  end

  // Read return: route to the head-of-FIFO requester; unmatched returns flag err.
  always_comb begin
    pop         = s_rvalid && !fifo_empty;
    err_d       = err_q || (s_rvalid && fifo_empty);
    rvalid_d[0] = pop && (fifo_head == 1'b0);
    rvalid_d[1] = pop && (fifo_head == 1'b1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      s_addr_q   <= ADDR_W'(0);
      s_wdata_q  <= DATA_W'(0);
      s_be_q     <= BE_W'(0);
      s_read_q   <= 1'b0;
      s_write_q  <= 1'b0;
      m0_rdata_q <= DATA_W'(0);
      m1_rdata_q <= DATA_W'(0);
      rvalid_q   <= 2'b00;
      err_q      <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_be_q     <= s_be_d;
      s_read_q   <= s_read_d;
      s_write_q  <= s_write_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      if (rvalid_d[0]) m0_rdata_q <= s_rdata;
      if (rvalid_d[1]) m1_rdata_q <= s_rdata;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_be      = s_be_q;
  assign s_read    = s_read_q;
  assign s_write   = s_write_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign err       = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (both priority builds).
module tb_sdram_port_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [23:0] m0_addr, m1_addr, s_addr;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_wdata, m1_wdata, s_wdata;
  logic [1:0]  m0_be, m1_be, s_be;
  logic        m0_waitrequest, m1_waitrequest;
  logic [15:0] m0_rdata, m1_rdata, s_rdata;
  logic        m0_rvalid, m1_rvalid;
  logic        s_read, s_write, s_waitrequest, s_rvalid, err;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_g;

  sdram_port_arbiter dut (
    .CLOCK_50       (CLOCK_50),
    .RESET          (RESET),
    .m0_addr        (m0_addr),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_wdata       (m0_wdata),
    .m0_be          (m0_be),
    .m0_waitrequest (m0_waitrequest),
    .m0_rdata       (m0_rdata),
    .m0_rvalid      (m0_rvalid),
    .m1_addr        (m1_addr),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_wdata       (m1_wdata),
    .m1_be          (m1_be),
    .m1_waitrequest (m1_waitrequest),
    .m1_rdata       (m1_rdata),
    .m1_rvalid      (m1_rvalid),
    .s_addr         (s_addr),
    .s_wdata        (s_wdata),
    .s_be           (s_be),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_waitrequest  (s_waitrequest),
    .s_rdata        (s_rdata),
    .s_rvalid       (s_rvalid),
    .err            (err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_inputs();
    m0_addr = 24'h0; m0_read = 1'b0; m0_write = 1'b0; m0_wdata = 16'h0; m0_be = 2'b00;
    m1_addr = 24'h0; m1_read = 1'b0; m1_write = 1'b0; m1_wdata = 16'h0; m1_be = 2'b00;
    s_waitrequest = 1'b0; s_rdata = 16'h0; s_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    cyc();
    cyc();
    RESET = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_read"}, {31'd0, s_read}, 32'd0);
    chk({tag, "_s_write"}, {31'd0, s_write}, 32'd0);
    chk({tag, "_s_addr"}, {8'd0, s_addr}, 32'd0);
    chk({tag, "_s_wdata_be"}, {14'd0, s_wdata, s_be}, 32'd0);
    chk({tag, "_waitreq"}, {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
    chk({tag, "_rvalid"}, {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_g = 4'b0000;
`else
    exp_g = 4'b1010;
`endif
    RESET = 1'b1;
    do_reset();
    @(negedge CLOCK_50);
    chk_reset_vals("reset");

    // Single write
    cyc();
    m0_write = 1'b1; m0_addr = 24'h000010; m0_wdata = 16'hBEEF; m0_be = 2'b11;
    @(negedge CLOCK_50);
    chk("wr_c0_waitreq", {31'd0, m0_waitrequest}, 32'd1);
    cyc();
    @(negedge CLOCK_50);
    chk("wr_c1_s_write", {31'd0, s_write}, 32'd1);
    chk("wr_c1_s_read", {31'd0, s_read}, 32'd0);
    chk("wr_c1_s_addr", {8'd0, s_addr}, 32'h10);
    chk("wr_c1_s_wdata", {16'd0, s_wdata}, 32'hBEEF);
    chk("wr_c1_s_be", {30'd0, s_be}, 32'd3);
    chk("wr_c1_waitreq", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
    cyc();
    m0_write = 1'b0;
    @(negedge CLOCK_50);
    chk("wr_c2_s_write", {31'd0, s_write}, 32'd0);

    // Tie between continuous readers, then FIFO-full behaviour
    do_reset();
    m0_read = 1'b1; m0_addr = 24'h000100;
    m1_read = 1'b1; m1_addr = 24'h000200;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge CLOCK_50);
      chk($sformatf("tie%0d_m0_wr", k), {31'd0, m0_waitrequest}, {31'd0, exp_g[k] != 1'b0});
      chk($sformatf("tie%0d_m1_wr", k), {31'd0, m1_waitrequest}, {31'd0, exp_g[k] != 1'b1});
      chk($sformatf("tie%0d_s_read", k), {31'd0, s_read}, 32'd1);
      chk($sformatf("tie%0d_s_addr", k), {8'd0, s_addr}, exp_g[k] ? 32'h200 : 32'h100);
      cyc();
    end
    m1_read = 1'b0;
    m1_write = 1'b1; m1_addr = 24'h000300; m1_wdata = 16'hCAFE; m1_be = 2'b01;
    @(negedge CLOCK_50);
    chk("full_c8_m0_wr", {31'd0, m0_waitrequest}, 32'd1);
    cyc();
    @(negedge CLOCK_50);
    chk("full_c9_s_write", {31'd0, s_write}, 32'd1);
    chk("full_c9_s_addr", {8'd0, s_addr}, 32'h300);
    chk("full_c9_waitreq", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd2);
    cyc();
    m1_write = 1'b0;
    @(negedge CLOCK_50);
    chk("full_c10_s_cmd", {30'd0, s_read, s_write}, 32'd0);
    cyc();
    s_rvalid = 1'b1; s_rdata = 16'hA5A5;
    @(negedge CLOCK_50);
    chk("full_c11_m0_wr", {31'd0, m0_waitrequest}, 32'd1);
    cyc();
    s_rvalid = 1'b0;
    @(negedge CLOCK_50);
    chk("full_c12_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
    chk("full_c12_m0_rdata", {16'd0, m0_rdata}, 32'hA5A5);
    chk("full_c12_s_read", {31'd0, s_read}, 32'd0);
    cyc();
    @(negedge CLOCK_50);
    chk("full_c13_s_read", {31'd0, s_read}, 32'd1);
    chk("full_c13_s_addr", {8'd0, s_addr}, 32'h100);
    chk("full_c13_m0_wr", {31'd0, m0_waitrequest}, 32'd0);
    cyc();
    m0_read = 1'b0;

    // Read routing back to the issuing requester, in order
    do_reset();
    m1_read = 1'b1; m1_addr = 24'h000020;
    cyc();
    @(negedge CLOCK_50);
    chk("rt_m1_accept", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd2);
    chk("rt_s_addr1", {8'd0, s_addr}, 32'h20);
    cyc();
    m1_read = 1'b0; m0_read = 1'b1; m0_addr = 24'h000030;
    cyc();
    @(negedge CLOCK_50);
    chk("rt_m0_accept", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
    chk("rt_s_addr0", {8'd0, s_addr}, 32'h30);
    cyc();
    m0_read = 1'b0; s_rvalid = 1'b1; s_rdata = 16'h1111;
    cyc();
    s_rdata = 16'h2222;
    @(negedge CLOCK_50);
    chk("rt_ret1_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd1);
    chk("rt_ret1_m1_rdata", {16'd0, m1_rdata}, 32'h1111);
    cyc();
    s_rvalid = 1'b0;
    @(negedge CLOCK_50);
    chk("rt_ret2_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd2);
    chk("rt_ret2_rdata", {m0_rdata, m1_rdata}, 32'h2222_1111);
    cyc();
    @(negedge CLOCK_50);
    chk("rt_ret3_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);

    // Controller stall for 5 cycles during ISSUE
    cyc();
    m0_write = 1'b1; m0_addr = 24'h000055; m0_wdata = 16'h1234; m0_be = 2'b10;
    s_waitrequest = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      @(negedge CLOCK_50);
      chk($sformatf("stall%0d_s_cmd", k), {30'd0, s_read, s_write}, 32'd1);
      chk($sformatf("stall%0d_s_addr", k), {8'd0, s_addr}, 32'h55);
      chk($sformatf("stall%0d_s_data", k), {14'd0, s_wdata, s_be}, {14'd0, 16'h1234, 2'b10});
      chk($sformatf("stall%0d_m0_wr", k), {31'd0, m0_waitrequest}, 32'd1);
    end
    cyc();
    s_waitrequest = 1'b0;
    @(negedge CLOCK_50);
    chk("stall6_m0_wr", {31'd0, m0_waitrequest}, 32'd0);
    chk("stall6_s_write", {31'd0, s_write}, 32'd1);
    cyc();
    m0_write = 1'b0;
    @(negedge CLOCK_50);
    chk("stall7_s_write", {31'd0, s_write}, 32'd0);

    // Unmatched return sets err; RESET mid-ISSUE clears everything
    cyc();
    s_rvalid = 1'b1; s_rdata = 16'h7777;
    cyc();
    s_rvalid = 1'b0;
    m0_read = 1'b1; m0_addr = 24'h000040; s_waitrequest = 1'b1;
    @(negedge CLOCK_50);
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_no_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("err_rdata_hold", {m0_rdata, m1_rdata}, 32'h2222_1111);
    cyc();
    @(negedge CLOCK_50);
    chk("rst_mid_s_read", {31'd0, s_read}, 32'd1);
    chk("err_sticky", {31'd0, err}, 32'd1);
    RESET = 1'b1;
    cyc();
    @(negedge CLOCK_50);
    chk_reset_vals("rst_mid");
    RESET = 1'b0;
    m0_read = 1'b0; s_waitrequest = 1'b0;
    cyc();
    @(negedge CLOCK_50);
    chk("post_rst_err", {31'd0, err}, 32'd0);
    chk("post_rst_s_cmd", {30'd0, s_read, s_write}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
